rs_station: RTL and testbench

- Reservation station between dispatch and the functional units in the OoO core.
- Each dispatched instruction is allocated into a free entry, tagged with the ROB tail tag (tail_to_rs).
- Entries hold until both source operands are captured, either at dispatch or from the CDB broadcast.
- Ready entries issue one per cycle to the FU issue port, under a valid/ready handshake.

---
 rtl/rs_station.sv | 103 ++++++++++
 tb/tb_rs_station.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rs_station.sv
// rs_station: reservation station with CDB wakeup, dispatch/CDB bypass and lowest-index issue select.
// Dispatch fills the lowest free entry; the lowest ready entry is presented to the FU each cycle.
module rs_station #(
  parameter int RS_SIZE   = 4,
  parameter int TAG_W     = 3,
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [TAG_W-1:0]          disp_rob_tag,
  input  logic [PAYLOAD_W-1:0]      disp_payload,
  input  logic                      disp_src1_rdy,
  input  logic [TAG_W-1:0]          disp_src1_tag,
  input  logic [XLEN-1:0]           disp_src1_val,
  input  logic                      disp_src2_rdy,
  input  logic [TAG_W-1:0]          disp_src2_tag,
  input  logic [XLEN-1:0]           disp_src2_val,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [XLEN-1:0]           cdb_value,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [TAG_W-1:0]          issue_rob_tag,
  output logic [PAYLOAD_W-1:0]      issue_payload,
  output logic [XLEN-1:0]           issue_src1_val,
  output logic [XLEN-1:0]           issue_src2_val,
  output logic [$clog2(RS_SIZE):0]  free_count
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;
  logic [RS_SIZE-1:0]   valid, s1_rdy, s2_rdy, issuable;
  logic [TAG_W-1:0]     rob_tag [RS_SIZE];
  logic [TAG_W-1:0]     s1_tag  [RS_SIZE];
  logic [TAG_W-1:0]     s2_tag  [RS_SIZE];
  logic [XLEN-1:0]      s1_val  [RS_SIZE];
  logic [XLEN-1:0]      s2_val  [RS_SIZE];
  logic [PAYLOAD_W-1:0] payload [RS_SIZE];
  logic [IW-1:0]        alloc_idx, issue_idx;
  logic                 alloc, fire, byp1, byp2;
  assign issuable = valid & s1_rdy & s2_rdy;
  // Descending scan so the lowest index wins both priority encoders.
  always_comb begin
    alloc_idx  = '0;
    issue_idx  = '0;
    free_count = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = IW'(i);
      if (issuable[i]) issue_idx = IW'(i);
      free_count = free_count + CW'(!valid[i]);
    end
  end
  assign disp_ready     = free_count != '0;
  assign issue_valid    = |issuable;
  assign issue_rob_tag  = rob_tag[issue_idx];
  assign issue_payload  = payload[issue_idx];
  assign issue_src1_val = s1_val[issue_idx];
  assign issue_src2_val = s2_val[issue_idx];
  assign alloc = disp_valid && disp_ready;
  assign fire  = issue_valid && issue_ready;
  assign byp1  = !disp_src1_rdy && cdb_valid && cdb_tag == disp_src1_tag;
  assign byp2  = !disp_src2_rdy && cdb_valid && cdb_tag == disp_src2_tag;
  // The allocated entry is always invalid and the issued one valid, so their writes never collide.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (valid[i] && cdb_valid && !s1_rdy[i] && s1_tag[i] == cdb_tag) begin
          s1_rdy[i] <= 1'b1;
          s1_val[i] <= cdb_value;
        end
        if (valid[i] && cdb_valid && !s2_rdy[i] && s2_tag[i] == cdb_tag) begin
          s2_rdy[i] <= 1'b1;
          s2_val[i] <= cdb_value;
        end
      end
      if (fire) valid[issue_idx] <= 1'b0;
      if (alloc) begin
        valid[alloc_idx]   <= 1'b1;
        rob_tag[alloc_idx] <= disp_rob_tag;
        payload[alloc_idx] <= disp_payload;
        s1_rdy[alloc_idx]  <= disp_src1_rdy || byp1;
        s1_tag[alloc_idx]  <= disp_src1_tag;
        s1_val[alloc_idx]  <= disp_src1_rdy ? disp_src1_val : cdb_value;
        s2_rdy[alloc_idx]  <= disp_src2_rdy || byp2;
        s2_tag[alloc_idx]  <= disp_src2_tag;
        s2_val[alloc_idx]  <= disp_src2_rdy ? disp_src2_val : cdb_value;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (int'(free_count) == RS_SIZE - $countones(valid));
      for (int i = 0; i < RS_SIZE; i++)
        for (int j = i + 1; j < RS_SIZE; j++)
          assert (!(valid[i] && valid[j] && rob_tag[i] == rob_tag[j]));
    end
  end
endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed vector table for the multi-cycle corner cases, then random traffic
// checked against an entry-list reference model.
module tb_rs_station;
  logic        clock = 1'b0, reset, squash, disp_valid, disp_ready;
  logic [2:0]  disp_rob_tag, disp_src1_tag, disp_src2_tag, cdb_tag, issue_rob_tag;
  logic [31:0] disp_payload, disp_src1_val, disp_src2_val, cdb_value;
  logic [31:0] issue_payload, issue_src1_val, issue_src2_val;
  logic        disp_src1_rdy, disp_src2_rdy, cdb_valid, issue_valid, issue_ready;
  logic [2:0]  free_count;
  int          n_vec = 0, n_err = 0;

  rs_station dut (
    .clock(clock), .reset(reset), .squash(squash),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob_tag(disp_rob_tag),
    .disp_payload(disp_payload),
    .disp_src1_rdy(disp_src1_rdy), .disp_src1_tag(disp_src1_tag), .disp_src1_val(disp_src1_val),
    .disp_src2_rdy(disp_src2_rdy), .disp_src2_tag(disp_src2_tag), .disp_src2_val(disp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob_tag(issue_rob_tag),
    .issue_payload(issue_payload), .issue_src1_val(issue_src1_val),
    .issue_src2_val(issue_src2_val), .free_count(free_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst, sq, dv; logic [2:0] dt;
    logic s1r; logic [2:0] s1t; logic [31:0] s1v;
    logic s2r; logic [2:0] s2t; logic [31:0] s2v;
    logic cv; logic [2:0] ct; logic [31:0] cval; logic ir;
    logic eiv; logic [2:0] et; logic [31:0] e1, e2; logic [2:0] efc; logic edr;
  } vec_t;

  typedef struct {
    bit v; logic [2:0] tag; logic [31:0] pay;
    bit r1; logic [2:0] t1; logic [31:0] v1;
    bit r2; logic [2:0] t2; logic [31:0] v2;
  } ent_t;

  ent_t m [4];
  vec_t tbl [34];

  function automatic vec_t v(input logic rst, sq, dv, input logic [2:0] dt,
      input logic s1r, input logic [2:0] s1t, input logic [31:0] s1v,
      input logic s2r, input logic [2:0] s2t, input logic [31:0] s2v,
      input logic cv, input logic [2:0] ct, input logic [31:0] cval, input logic ir,
      input logic eiv, input logic [2:0] et, input logic [31:0] e1, e2,
      input logic [2:0] efc, input logic edr);
    vec_t r;
    r.rst = rst; r.sq = sq; r.dv = dv; r.dt = dt;
    r.s1r = s1r; r.s1t = s1t; r.s1v = s1v; r.s2r = s2r; r.s2t = s2t; r.s2v = s2v;
    r.cv = cv; r.ct = ct; r.cval = cval; r.ir = ir;
    r.eiv = eiv; r.et = et; r.e1 = e1; r.e2 = e2; r.efc = efc; r.edr = edr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, sq, dv, input logic [2:0] dt,
      input logic s1r, input logic [2:0] s1t, input logic [31:0] s1v,
      input logic s2r, input logic [2:0] s2t, input logic [31:0] s2v,
      input logic cv, input logic [2:0] ct, input logic [31:0] cval, input logic ir);
    reset = rst; squash = sq; disp_valid = dv; disp_rob_tag = dt;
    disp_payload = 32'hC0DE_0000 | 32'(dt);
    disp_src1_rdy = s1r; disp_src1_tag = s1t; disp_src1_val = s1v;
    disp_src2_rdy = s2r; disp_src2_tag = s2t; disp_src2_val = s2v;
    cdb_valid = cv; cdb_tag = ct; cdb_value = cval; issue_ready = ir;
  endtask

  function automatic bit tag_used(input logic [2:0] t);
    for (int i = 0; i < 4; i++) if (m[i].v && m[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1; @(posedge clock); #1;
    chk("reset disp_ready", 32'(disp_ready), 1);
    chk("reset issue_valid", 32'(issue_valid), 0);
    chk("reset free_count", 32'(free_count), 4);
    //          rst sq dv dt s1r s1t s1v  s2r s2t s2v  cv ct cval  ir   eiv et e1 e2 efc edr
    tbl[0]  = v(0, 0, 1, 2, 1, 0, 5,     1, 0, 7,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1,   1, 2, 5, 7, 3, 1);
    tbl[2]  = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[3]  = v(0, 0, 1, 0, 0, 7, 0,     0, 7, 0,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[4]  = v(0, 0, 1, 1, 0, 7, 0,     0, 7, 0,     0, 0, 0,     0,   0, 0, 0, 0, 3, 1);
    tbl[5]  = v(0, 0, 1, 2, 0, 7, 0,     0, 7, 0,     0, 0, 0,     0,   0, 0, 0, 0, 2, 1);
    tbl[6]  = v(0, 0, 1, 3, 0, 7, 0,     0, 7, 0,     0, 0, 0,     0,   0, 0, 0, 0, 1, 1);
    tbl[7]  = v(0, 0, 1, 4, 1, 0, 9,     1, 0, 9,     0, 0, 0,     0,   0, 0, 0, 0, 0, 0);
    tbl[8]  = v(0, 1, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0,   0, 0, 0, 0, 0, 0);
    tbl[9]  = v(0, 0, 1, 1, 0, 6, 0,     0, 7, 0,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[10] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 6, 'h10,  0,   0, 0, 0, 0, 3, 1);
    tbl[11] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 7, 'h20,  0,   0, 0, 0, 0, 3, 1);
    tbl[12] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1,   1, 1, 'h10, 'h20, 3, 1);
    tbl[13] = v(0, 0, 1, 3, 0, 5, 0,     1, 0, 'h55,  1, 5, 'hAB,  0,   0, 0, 0, 0, 4, 1);
    tbl[14] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1,   1, 3, 'hAB, 'h55, 3, 1);
    tbl[15] = v(0, 0, 1, 0, 0, 6, 0,     1, 0, 2,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[16] = v(0, 0, 1, 1, 1, 0, 'h11,  1, 0, 'h12,  0, 0, 0,     0,   0, 0, 0, 0, 3, 1);
    tbl[17] = v(0, 0, 1, 2, 0, 6, 0,     1, 0, 4,     0, 0, 0,     1,   1, 1, 'h11, 'h12, 2, 1);
    tbl[18] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 6, 'h66,  1,   0, 0, 0, 0, 2, 1);
    tbl[19] = v(0, 0, 1, 3, 0, 5, 0,     1, 0, 'h32,  0, 0, 0,     1,   1, 0, 'h66, 2, 2, 1);
    tbl[20] = v(0, 0, 1, 4, 0, 5, 0,     1, 0, 'h42,  0, 0, 0,     1,   1, 2, 'h66, 4, 2, 1);
    tbl[21] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     1, 5, 'h55,  0,   0, 0, 0, 0, 2, 1);
    tbl[22] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1,   1, 4, 'h55, 'h42, 2, 1);
    tbl[23] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1,   1, 3, 'h55, 'h32, 3, 1);
    tbl[24] = v(0, 0, 1, 0, 0, 7, 0,     0, 7, 0,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[25] = v(0, 0, 1, 1, 0, 7, 0,     0, 7, 0,     0, 0, 0,     0,   0, 0, 0, 0, 3, 1);
    tbl[26] = v(0, 0, 1, 2, 0, 7, 0,     0, 7, 0,     0, 0, 0,     0,   0, 0, 0, 0, 2, 1);
    tbl[27] = v(0, 1, 1, 5, 1, 0, 9,     1, 0, 9,     1, 7, 'h77,  0,   0, 0, 0, 0, 1, 1);
    tbl[28] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[29] = v(0, 0, 1, 6, 1, 0, 1,     1, 0, 1,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[30] = v(0, 1, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0,   1, 6, 1, 1, 3, 1);
    tbl[31] = v(0, 0, 1, 1, 1, 0, 3,     1, 0, 3,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    tbl[32] = v(1, 1, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     1,   1, 1, 3, 3, 3, 1);
    tbl[33] = v(0, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0, 0, 0,     0,   0, 0, 0, 0, 4, 1);
    for (int k = 0; k < 34; k++) begin
      chk($sformatf("row%0d issue_valid", k), 32'(issue_valid), 32'(tbl[k].eiv));
      chk($sformatf("row%0d free_count", k), 32'(free_count), 32'(tbl[k].efc));
      chk($sformatf("row%0d disp_ready", k), 32'(disp_ready), 32'(tbl[k].edr));
      if (tbl[k].eiv) begin
        chk($sformatf("row%0d issue_rob_tag", k), 32'(issue_rob_tag), 32'(tbl[k].et));
        chk($sformatf("row%0d issue_payload", k), issue_payload, 32'hC0DE_0000 | 32'(tbl[k].et));
        chk($sformatf("row%0d issue_src1_val", k), issue_src1_val, tbl[k].e1);
        chk($sformatf("row%0d issue_src2_val", k), issue_src2_val, tbl[k].e2);
      end
      drive(tbl[k].rst, tbl[k].sq, tbl[k].dv, tbl[k].dt, tbl[k].s1r, tbl[k].s1t, tbl[k].s1v,
            tbl[k].s2r, tbl[k].s2t, tbl[k].s2v, tbl[k].cv, tbl[k].ct, tbl[k].cval, tbl[k].ir);
      @(posedge clock); #1;
    end
    for (int i = 0; i < 4; i++) m[i].v = 1'b0;
    for (int c = 0; c < 600; c++) begin
      int fc, ii, jf;
      logic rst, sq, dv, s1r, s2r, cv, ir;
      logic [2:0] dt, s1t, s2t, ct;
      logic [31:0] s1v, s2v, cval;
      fc = 0; ii = -1; jf = -1;
      for (int i = 0; i < 4; i++) begin
        if (!m[i].v) begin
          fc++;
          if (jf < 0) jf = i;
        end else if (m[i].r1 && m[i].r2 && ii < 0) ii = i;
      end
      chk("rand free_count", 32'(free_count), 32'(fc));
      chk("rand disp_ready", 32'(disp_ready), 32'(fc != 0));
      chk("rand issue_valid", 32'(issue_valid), 32'(ii >= 0));
      if (ii >= 0) begin
        chk("rand issue_rob_tag", 32'(issue_rob_tag), 32'(m[ii].tag));
        chk("rand issue_payload", issue_payload, m[ii].pay);
        chk("rand issue_src1_val", issue_src1_val, m[ii].v1);
        chk("rand issue_src2_val", issue_src2_val, m[ii].v2);
      end
      rst = $urandom_range(0, 99) == 0;
      sq  = $urandom_range(0, 39) == 0;
      dv  = $urandom_range(0, 9) < 7;
      do dt = 3'($urandom_range(0, 7)); while (tag_used(dt));
      s1r = $urandom_range(0, 1) == 1; s1t = 3'($urandom_range(0, 7)); s1v = $urandom;
      s2r = $urandom_range(0, 1) == 1; s2t = 3'($urandom_range(0, 7)); s2v = $urandom;
      cv  = $urandom_range(0, 1) == 1; ct  = 3'($urandom_range(0, 7)); cval = $urandom;
      ir  = $urandom_range(0, 9) < 6;
      drive(rst, sq, dv, dt, s1r, s1t, s1v, s2r, s2t, s2v, cv, ct, cval, ir);
      if (rst || sq) begin
        for (int i = 0; i < 4; i++) m[i].v = 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (m[i].v && cv && !m[i].r1 && m[i].t1 == ct) begin m[i].r1 = 1'b1; m[i].v1 = cval; end
          if (m[i].v && cv && !m[i].r2 && m[i].t2 == ct) begin m[i].r2 = 1'b1; m[i].v2 = cval; end
        end
        if (ii >= 0 && ir) m[ii].v = 1'b0;
        if (dv && jf >= 0) begin
          m[jf].v = 1'b1; m[jf].tag = dt; m[jf].pay = 32'hC0DE_0000 | 32'(dt);
          m[jf].t1 = s1t; m[jf].r1 = s1r || (cv && ct == s1t); m[jf].v1 = s1r ? s1v : cval;
          m[jf].t2 = s2t; m[jf].r2 = s2r || (cv && ct == s2t); m[jf].v2 = s2r ? s2v : cval;
        end
      end
      @(posedge clock); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
